// File: rtl/march_addr_gen_pkg.sv
// Shared types and constants for the march-element address generator.
// Latency: n/a. Backpressure: n/a.
package march_addr_gen_pkg;

    localparam int ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // lu has priority over ld when both are requested.
    function automatic logic sel_dir(input logic lu, input logic ld);
        return lu ? DIR_UP : (ld ? DIR_DN : DIR_UP);
    endfunction

endpackage

// File: rtl/march_addr_gen_if.sv
// Controller-side bundle of the march address generator (addr_lim only with MARCH_ADDR_LIMIT_EN).
// Latency: n/a. Backpressure: hold stalls the sweep.
interface march_addr_gen_if #(
    parameter int AW = march_addr_gen_pkg::ADDR_WIDTH
);
    logic          start;
    logic          lu_in;
    logic          ld_in;
    logic          hold;
`ifdef MARCH_ADDR_LIMIT_EN
    logic [AW-1:0] addr_lim;
`endif
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic          last;
    logic          done;
    logic          busy;
    logic          dir_err;

`ifdef MARCH_ADDR_LIMIT_EN
    modport master (
        output start, lu_in, ld_in, hold, addr_lim,
        input  addr_out, addr_valid, last, done, busy, dir_err
    );
    modport slave (
        input  start, lu_in, ld_in, hold, addr_lim,
        output addr_out, addr_valid, last, done, busy, dir_err
    );
`else
    modport master (
        output start, lu_in, ld_in, hold,
        input  addr_out, addr_valid, last, done, busy, dir_err
    );
    modport slave (
        input  start, lu_in, ld_in, hold,
        output addr_out, addr_valid, last, done, busy, dir_err
    );
`endif

endinterface

// File: rtl/march_addr_gen_updown_counter.sv
// Loadable up/down address counter with terminal-count flag (bound when up, zero when down).
// Latency: load/step visible one cycle later. Backpressure: counter holds while i_en is low.
module march_addr_gen_updown_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_dir,
    input  logic [W-1:0] i_bound,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);
    import march_addr_gen_pkg::*;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= (i_dir == DIR_UP) ? r_cnt + W'(1) : r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (i_dir == DIR_UP) ? (r_cnt == i_bound) : (r_cnt == '0);

endmodule

// File: rtl/march_addr_gen.sv
// March-element address sweep (0..bound or bound..0); bound from addr_lim when MARCH_ADDR_LIMIT_EN.
// Latency: first address one cycle after start. Backpressure: hold freezes address/valid/last.
module march_addr_gen #(
    parameter int ADDR_WIDTH = march_addr_gen_pkg::ADDR_WIDTH,
    parameter int MAX_ADDR   = 2**ADDR_WIDTH - 1
) (
    input  logic            clk,
    input  logic            rst,
    march_addr_gen_if.slave bus
);
    import march_addr_gen_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDR);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_dir;
    logic                    r_dir_err;
    logic [ADDR_WIDTH-1:0]   r_bound;
    logic                    w_load;
    logic                    w_en;
    logic                    w_tc;
    logic                    w_dir_ok;
    logic                    w_start_idle;
    logic                    w_valid;
    logic [ADDR_WIDTH-1:0]   w_bound_in;
    logic [ADDR_WIDTH-1:0]   w_load_val;
    logic [ADDR_WIDTH-1:0]   w_cnt;

`ifdef MARCH_ADDR_LIMIT_EN
    assign w_bound_in = bus.addr_lim;
`else
    assign w_bound_in = MAX_A;
`endif

    assign w_dir_ok     = bus.lu_in | bus.ld_in;
    assign w_start_idle = (r_state == IDLE) && bus.start;
    assign w_load_val   = (sel_dir(bus.lu_in, bus.ld_in) == DIR_UP) ? '0 : w_bound_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && w_dir_ok) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (!bus.hold) begin
                    if (w_tc) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Direction and bound are captured only on an accepted start, so later
    // lu/ld/addr_lim changes cannot disturb a sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir     <= DIR_UP;
            r_bound   <= '0;
            r_dir_err <= 1'b0;
        end else if (w_start_idle) begin
            if (w_dir_ok) begin
                r_dir   <= sel_dir(bus.lu_in, bus.ld_in);
                r_bound <= w_bound_in;
            end else begin
                r_dir_err <= 1'b1;
            end
        end
    end

    march_addr_gen_updown_counter #(
        .W (ADDR_WIDTH)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .i_dir      (r_dir),
        .i_bound    (r_bound),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    assign w_valid        = (r_state == RUN);
    assign bus.addr_valid = w_valid;
    assign bus.addr_out   = w_valid ? w_cnt : '0;
    assign bus.last       = w_valid & w_tc;
    assign bus.done       = (r_state == DONE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.dir_err    = r_dir_err;

endmodule

// File: doc/march_addr_gen.md
Name: march_addr_gen

Overview:
- Sequential counterpart of the march-element decoder in the memory BIST datapath.
- The decoder turns an address/step word into an up/down (lu/ld) indication. This block takes that indication and produces the address sweep for one march element toward the memory under test.
- The sweep runs ascending 0..MAX or descending MAX..0.
- The sweep is started by the BIST controller and can be stalled by it.

Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH (from defines.v), width of the generated address.
- MAX_ADDR, default 2**ADDR_WIDTH-1, last address of the sweep.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- lu_in  input  1  ascending-order request, from the decoder lu_out
- ld_in  input  1  descending-order request, from the decoder ld_out
- hold  input  1  stall; the current address is held while high
- addr_out  output  ADDR_WIDTH  current memory address
- addr_valid  output  1  addr_out is valid this cycle
- last  output  1  addr_out is the final address of the sweep
- done  output  1  one-cycle pulse after the final address is consumed
- busy  output  1  high in RUN and DONE
- dir_err  output  1  sticky flag: start was received with lu_in=ld_in=0

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous, active-high, and overrides all other inputs.
  - Reset values: state=IDLE, addr_out=0, addr_valid=0, last=0, done=0, busy=0, dir_err=0.
  - rst during RUN or DONE aborts the sweep. Outputs take reset values on the next edge; no done pulse is produced.
- Direction latch: sampled with start.
  - lu_in=1 gives ascending, whatever ld_in is (lu has priority).
  - lu_in=0, ld_in=1 gives descending.
  - Both 0: dir_err is set, the block stays in IDLE, and no done pulse is produced. dir_err clears only on rst.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start with a valid direction. The next cycle shows addr_out = 0 (ascending) or MAX_ADDR (descending) with addr_valid=1, so latency from start to first address is 1 cycle.
  - RUN, hold=0, not last: addr_out increments or decrements by 1 on the next edge.
  - RUN, hold=1: addr_out, addr_valid and last are frozen.
  - RUN, last=1, hold=0: go to DONE; addr_valid drops next cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- last is high while addr_out equals MAX_ADDR (ascending) or 0 (descending), and while addr_valid is high.
- The counter never wraps: no value beyond MAX_ADDR or below 0 is ever presented.
- A sweep with no holds presents MAX_ADDR+1 addresses in MAX_ADDR+1 consecutive cycles.
- start in RUN or DONE is ignored; it is not queued.
- lu_in and ld_in changes after the start cycle have no effect on the current sweep.
- MAX_ADDR=0 is legal: one address with last=1 in the first RUN cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: MARCH_ADDR_LIMIT_EN.
- When defined:
  - Adds input addr_lim [ADDR_WIDTH-1:0], sampled with start. It replaces MAX_ADDR as the sweep bound, giving a 0..addr_lim / addr_lim..0 sweep for partial-array test.
  - addr_lim is ignored outside the start cycle.
- When undefined: the port is absent and the bound is the MAX_ADDR parameter.

Decomposition:
- Shared package / defines.v holds:
  - ADDR_WIDTH
  - FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - direction constants (DIR_UP=1'b1, DIR_DN=1'b0)
- One natural sub-module, updown_counter: load value, enable, direction, terminal-count output. The FSM and direction latch stay in march_addr_gen.

Test Plan:
- ADDR_WIDTH=3, start with lu_in=1, hold=0:
  - addr_out 0..7 on cycles 1..8
  - last only at 7
  - done pulse at cycle 9
  - busy low at cycle 10.
- start with lu_in=0, ld_in=1:
  - addr_out 7,6,...,0
  - last at 0
  - done one cycle after.
- Ascending sweep, hold=1 for 3 cycles while addr_out=4: addr_out stays 4 and addr_valid stays 1 for 4 cycles, then resumes at 5.
- start with lu_in=ld_in=0:
  - dir_err=1 next cycle; busy, addr_valid and done stay 0.
  - Subsequent valid start works and dir_err stays 1 until rst.
- Reset and ignored start:
  - rst asserted while addr_out=3: next cycle all outputs are 0 and no done pulse.
  - start pulsed in RUN: the sweep is unaffected.
- MARCH_ADDR_LIMIT_EN defined, addr_lim=2, lu_in=1: addr_out 0,1,2, last at 2, done follows.
